mc_ctl_fsm: RTL and testbench
=============================

# mc_ctl_fsm

Multicycle control sequencer for the RV32I core. It steps the shared datapath (one ALU, one unified instruction/data memory port, PC/IR/ALUOut/Data registers) through fetch, decode, execute, memory and writeback. It replaces the single-cycle control unit when the core is built with a unified memory. It drives every datapath select and write-enable each cycle and stalls on a memory-ready handshake.

## Interface
- No parameters.
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- op  in  7  IR[6:0], valid from DECODE onward
- funct3  in  3  IR[14:12]
- funct7_5  in  1  IR[30]
- zero  in  1  ALU zero flag, same cycle
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access active this cycle
- adrsrc  out  1  0 = PC, 1 = Result
- irwrite  out  1  load IR and OldPC
- pcwrite  out  1  load PC from Result
- memwrite  out  1  store strobe
- regwrite  out  1  register-file write
- alusrca  out  2  00 PC, 01 OldPC, 10 RD1
- alusrcb  out  2  00 RD2, 01 ImmExt, 10 constant 4
- resultsrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
- immsrc  out  2  00 I, 01 S, 10 B, 11 J
- alucontrol  out  3  ALU_* code
- illegal  out  1  one-cycle pulse on unsupported opcode
- instret  out  32  retired-instruction count (macro-gated)

## Operation
- Moore FSM. States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL.
- Outputs are combinational from the state register. Only the handshake strobes are also gated by mem_ready.
- FETCH:
  - mem_req=1, adrsrc=0, alusrca=00, alusrcb=10, aluop=00, resultsrc=10.
  - irwrite and pcwrite = mem_ready.
  - On mem_ready go to DECODE, else stay in FETCH.
- DECODE:
  - alusrca=01, alusrcb=01, aluop=00, immsrc=10. This computes the branch target into ALUOut.
  - Next state by op:
    - TYPE_I_LOAD, TYPE_S → MEMADR
    - TYPE_R → EXECR
    - TYPE_I_ALU → EXECI
    - TYPE_B → BEQ
    - TYPE_J → JAL
    - any other op → FETCH with illegal=1
- MEMADR: alusrca=10, alusrcb=01, immsrc=00 for load or 01 for store. Next: load → MEMREAD, store → MEMWRITE.
- MEMREAD: mem_req=1, adrsrc=1, resultsrc=00. Go to MEMWB on mem_ready, else stay.
- MEMWB: resultsrc=01, regwrite=1. Next: FETCH.
- MEMWRITE: mem_req=1, adrsrc=1, resultsrc=00, memwrite=mem_ready. Go to FETCH on mem_ready, else stay.
- EXECR: alusrca=10, alusrcb=00, aluop=10. Next: ALUWB.
- EXECI: alusrca=10, alusrcb=01, immsrc=00, aluop=10. Next: ALUWB.
- ALUWB: resultsrc=00, regwrite=1. Next: FETCH.
- BEQ:
  - alusrca=10, alusrcb=00, aluop=01, resultsrc=00.
  - pcwrite = zero when funct3==000. Any other funct3 gives no branch and no illegal pulse.
  - Next: FETCH.
- JAL: alusrca=01, alusrcb=10, aluop=00, resultsrc=00, pcwrite=1. Next: ALUWB.
- All outputs not listed for a state are 0.
- alucontrol comes from aluop, funct3, op[5] and funct7_5 using the core's ALU decode rules: SUB only when aluop=10, funct3=000 and op[5]&funct7_5.

## Timing
- Reset (asynchronous, rst_n low): state=FETCH, instret=0.
  - With mem_ready low every strobe is 0.
  - Select outputs hold their FETCH values (alusrcb=10, resultsrc=10); all others are 0.
- Cycle counts with zero wait states: BEQ 3; R, I-ALU, SW 4; JAL 4; LW 5.
- Each cycle with mem_ready low in FETCH, MEMREAD or MEMWRITE adds exactly one cycle. Nothing advances and no strobe fires.
- mem_ready is ignored outside memory states.
- rst_n asserted mid-instruction aborts immediately. No partial writes are issued after the assert edge.

## Configuration
- MC_CTL_INSTRET_EN defined:
  - instret increments by 1 on every transition into FETCH from ALUWB, MEMWB, MEMWRITE or BEQ.
  - It does not increment on the illegal-opcode return.
  - It wraps at 2^32.
- Undefined: instret is tied to 0 and no counter flops are built.

## Structure
- mc_state_t enum and the alusrca/alusrcb/resultsrc encoding constants are added to package constants, alongside TYPE_* and ALU_*.
- One sub-module: instantiate the core's existing alu_decoder for aluop→alucontrol. The FSM supplies aluop internally.

## Test plan
- addi x1,x0,5 with mem_ready tied 1 → FETCH, DECODE, EXECI, ALUWB. regwrite=1 in cycle 4 only; instret=1.
- lw with mem_ready low for 2 cycles in MEMREAD → 7 cycles total; regwrite asserted only in MEMWB.
- sw with mem_ready=1 → memwrite pulses exactly once, in cycle 4, with adrsrc=1.
- beq with zero=1 → pcwrite=1 in cycle 3. With zero=0 → pcwrite=0 and FETCH follows.
- op=7'b0000000 → illegal pulses in DECODE, next state FETCH, instret unchanged.
- rst_n low during MEMWRITE with mem_ready=1 → memwrite drops asynchronously, state=FETCH, instret=0.

Source files
------------

// File: rtl/mc_ctl_fsm_pkg.sv
// Shared constants for the multicycle control sequencer: opcode classes, ALU codes,
// datapath select encodings and the sequencer state type.
package mc_ctl_fsm_pkg;

  localparam logic [6:0] TYPE_R      = 7'b0110011;
  localparam logic [6:0] TYPE_I_ALU  = 7'b0010011;
  localparam logic [6:0] TYPE_I_LOAD = 7'b0000011;
  localparam logic [6:0] TYPE_S      = 7'b0100011;
  localparam logic [6:0] TYPE_B      = 7'b1100011;
  localparam logic [6:0] TYPE_J      = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL
  } mc_state_t;

  function automatic logic is_legal_op(input logic [6:0] op);
    is_legal_op = (op == TYPE_R) || (op == TYPE_I_ALU) || (op == TYPE_I_LOAD) ||
                  (op == TYPE_S) || (op == TYPE_B) || (op == TYPE_J);
  endfunction

endpackage

// File: rtl/mc_ctl_fsm_alu_decoder.sv
// ALU operation decoder: maps the sequencer's aluop plus instruction fields to an ALU code.
module mc_ctl_fsm_alu_decoder
  import mc_ctl_fsm_pkg::*;
(
  input  logic [1:0] aluop_i,
  input  logic [2:0] funct3_i,
  input  logic       op5_i,
  input  logic       funct7_5_i,
  output logic [2:0] alucontrol_o
);

  // ALU code selection
  always_comb begin
    alucontrol_o = ALU_ADD;
    case (aluop_i)
      ALUOP_ADD: alucontrol_o = ALU_ADD;
      ALUOP_SUB: alucontrol_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          3'b000:  alucontrol_o = (op5_i & funct7_5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  alucontrol_o = ALU_SLT;
          3'b100:  alucontrol_o = ALU_XOR;
          3'b110:  alucontrol_o = ALU_OR;
          3'b111:  alucontrol_o = ALU_AND;
          default: alucontrol_o = ALU_ADD;
        endcase
      end
      default: alucontrol_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_ctl_fsm.sv
// Multicycle RV32I control sequencer (Moore FSM with mem_ready-gated strobes).
// Optional retired-instruction counter enabled by defining MC_CTL_INSTRET_EN.
module mc_ctl_fsm
  import mc_ctl_fsm_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  op,
  input  logic [2:0]  funct3,
  input  logic        funct7_5,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        adrsrc,
  output logic        irwrite,
  output logic        pcwrite,
  output logic        memwrite,
  output logic        regwrite,
  output logic [1:0]  alusrca,
  output logic [1:0]  alusrcb,
  output logic [1:0]  resultsrc,
  output logic [1:0]  immsrc,
  output logic [2:0]  alucontrol,
  output logic        illegal,
  output logic [31:0] instret
);

  mc_state_t  state_q;
  logic [1:0] aluop_s;

  // State register and next-state sequencing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      case (state_q)
        S_FETCH:    if (mem_ready) state_q <= S_DECODE;
        S_DECODE: begin
          case (op)
            TYPE_I_LOAD, TYPE_S: state_q <= S_MEMADR;
            TYPE_R:              state_q <= S_EXECR;
            TYPE_I_ALU:          state_q <= S_EXECI;
            TYPE_B:              state_q <= S_BEQ;
            TYPE_J:              state_q <= S_JAL;
            default:             state_q <= S_FETCH;
          endcase
        end
        S_MEMADR:   state_q <= (op == TYPE_S) ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (mem_ready) state_q <= S_MEMWB;
        S_MEMWRITE: if (mem_ready) state_q <= S_FETCH;
        S_EXECR, S_EXECI, S_JAL: state_q <= S_ALUWB;
        S_MEMWB, S_ALUWB, S_BEQ: state_q <= S_FETCH;
        default:    state_q <= S_FETCH;
      endcase
    end
  end

  // Datapath controls decoded from the current state
  always_comb begin
    mem_req   = 1'b0;
    adrsrc    = 1'b0;
    irwrite   = 1'b0;
    pcwrite   = 1'b0;
    memwrite  = 1'b0;
    regwrite  = 1'b0;
    illegal   = 1'b0;
    alusrca   = SRCA_PC;
    alusrcb   = SRCB_RD2;
    resultsrc = RES_ALUOUT;
    immsrc    = IMM_I;
    aluop_s   = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        alusrcb   = SRCB_FOUR;
        resultsrc = RES_ALURESULT;
        irwrite   = mem_ready;
        pcwrite   = mem_ready;
      end
      S_DECODE: begin
        alusrca = SRCA_OLDPC;
        alusrcb = SRCB_IMM;
        immsrc  = IMM_B;
        illegal = ~is_legal_op(op);
      end
      S_MEMADR: begin
        alusrca = SRCA_RD1;
        alusrcb = SRCB_IMM;
        immsrc  = (op == TYPE_S) ? IMM_S : IMM_I;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adrsrc  = 1'b1;
      end
      S_MEMWB: begin
        resultsrc = RES_DATA;
        regwrite  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req  = 1'b1;
        adrsrc   = 1'b1;
        memwrite = mem_ready;
      end
      S_EXECR: begin
        alusrca = SRCA_RD1;
        aluop_s = ALUOP_FUNCT;
      end
      S_EXECI: begin
        alusrca = SRCA_RD1;
        alusrcb = SRCB_IMM;
        aluop_s = ALUOP_FUNCT;
      end
      S_ALUWB:  regwrite = 1'b1;
      S_BEQ: begin
        alusrca = SRCA_RD1;
        aluop_s = ALUOP_SUB;
        pcwrite = zero & (funct3 == 3'b000);
      end
      S_JAL: begin
        alusrca = SRCA_OLDPC;
        alusrcb = SRCB_FOUR;
        pcwrite = 1'b1;
      end
      default: begin
        mem_req = 1'b0;
      end
    endcase
  end

  mc_ctl_fsm_alu_decoder u_alu_decoder (
    .aluop_i      (aluop_s),
    .funct3_i     (funct3),
    .op5_i        (op[5]),
    .funct7_5_i   (funct7_5),
    .alucontrol_o (alucontrol)
  );

`ifdef MC_CTL_INSTRET_EN
  logic [31:0] instret_q;
  logic        retire_s;

  // Illegal-opcode returns come from DECODE and are deliberately not counted
  assign retire_s = (state_q == S_ALUWB) || (state_q == S_MEMWB) || (state_q == S_BEQ) ||
                    ((state_q == S_MEMWRITE) && mem_ready);

  // Retired-instruction counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_q <= 32'd0;
    end else if (retire_s) begin
      instret_q <= instret_q + 32'd1;
    end
  end

  assign instret = instret_q;
`else
  assign instret = 32'd0;
`endif

endmodule

// File: tb/tb_mc_ctl_fsm.sv
// Self-checking bench for mc_ctl_fsm: table-driven instruction vectors, hand sequences
// for stalls and mid-instruction reset, and randomized instructions against a timeline model.
module tb_mc_ctl_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic        zero;
  logic        mem_ready;
  logic        mem_req, adrsrc, irwrite, pcwrite, memwrite, regwrite, illegal;
  logic [1:0]  alusrca, alusrcb, resultsrc, immsrc;
  logic [2:0]  alucontrol;
  logic [31:0] instret;

  int vectors = 0;
  int miscompares = 0;
  int exp_ret = 0;

  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_B = 4, K_J = 5, K_BAD = 6;

  mc_ctl_fsm dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .adrsrc(adrsrc),
    .irwrite(irwrite), .pcwrite(pcwrite), .memwrite(memwrite), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .resultsrc(resultsrc), .immsrc(immsrc),
    .alucontrol(alucontrol), .illegal(illegal), .instret(instret)
  );

  always #5 clk = ~clk;

  function automatic int kind_of(input logic [6:0] o);
    case (o)
      7'b0000011: return K_LW;
      7'b0100011: return K_SW;
      7'b0110011: return K_R;
      7'b0010011: return K_I;
      7'b1100011: return K_B;
      7'b1101111: return K_J;
      default:    return K_BAD;
    endcase
  endfunction

  // Instruction length in cycles with no wait states
  function automatic int len_of(input int k);
    case (k)
      K_LW:    return 5;
      K_B:     return 3;
      K_BAD:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [2:0] alu_ref(input logic [2:0] f3, input logic o5, input logic f7);
    case (f3)
      3'b000:  return (o5 && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b100:  return 3'b100;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_instret();
`ifdef MC_CTL_INSTRET_EN
    check("instret", {32'd0, instret}, {32'd0, exp_ret[31:0]});
`else
    check("instret", {32'd0, instret}, 64'd0);
`endif
  endtask

  // Runs one instruction from FETCH. mode 0: ready always; 1: random ready; 2: nstall waits in data phase
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z,
                           input int mode, input int nstall,
                           output int cyc, output int n_rw, output int n_mw,
                           output int n_pw, output int n_ill);
    int k, len, p, stalls;
    logic rdy, is_mem;
    logic [11:0] expv, actv;
    k = kind_of(o); len = len_of(k);
    p = 0; cyc = 0; stalls = 0; n_rw = 0; n_mw = 0; n_pw = 0; n_ill = 0;
    op = o; funct3 = f3; funct7_5 = f7; zero = z;
    while (p < len && cyc < 64) begin
      is_mem = (p == 0) || ((k == K_LW || k == K_SW) && p == 3);
      if (mode == 1) rdy = 1'($urandom_range(0, 1));
      else if (mode == 2 && p == 3 && stalls < nstall) begin rdy = 1'b0; stalls++; end
      else rdy = 1'b1;
      mem_ready = rdy;
      @(negedge clk);
      expv[11]  = is_mem;
      expv[10]  = is_mem && (p != 0);
      expv[9]   = (p == 0) && rdy;
      expv[8]   = ((p == 0) && rdy) || (k == K_B && p == 2 && f3 == 3'b000 && z) || (k == K_J && p == 2);
      expv[7]   = (k == K_SW) && (p == 3) && rdy;
      expv[6]   = (k == K_LW || k == K_R || k == K_I || k == K_J) && (p == len - 1);
      expv[5]   = (k == K_BAD) && (p == 1);
      expv[4:3] = (p == 0) ? 2'b10 : ((k == K_LW && p == 4) ? 2'b01 : 2'b00);
      expv[2:0] = (p == 2 && (k == K_R || k == K_I)) ? alu_ref(f3, o[5], f7) :
                  ((p == 2 && k == K_B) ? 3'b001 : 3'b000);
      actv = {mem_req, adrsrc, irwrite, pcwrite, memwrite, regwrite, illegal, resultsrc, alucontrol};
      check($sformatf("cycle op=%b p=%0d", o, p), {52'd0, actv}, {52'd0, expv});
      n_rw += int'(regwrite); n_mw += int'(memwrite); n_pw += int'(pcwrite); n_ill += int'(illegal);
      @(posedge clk); #1;
      cyc++;
      if (!(is_mem && !rdy)) p++;
    end
    if (p < len) check("instr_timeout", 64'd1, 64'd0);
    if (k != K_BAD) exp_ret++;
    check_instret();
  endtask

  typedef struct {
    logic [6:0] op; logic [2:0] f3; logic f7; logic z;
    int cyc; int rw; int mw; int pw; int ill;
  } vec_t;

  vec_t tbl[10];
  logic [6:0] ops[8];

  initial begin
    int c, rw, mw, pw, il;
    tbl[0] = '{7'b0010011, 3'b000, 1'b0, 1'b0, 4, 1, 0, 1, 0};  // addi
    tbl[1] = '{7'b0110011, 3'b000, 1'b0, 1'b0, 4, 1, 0, 1, 0};  // add
    tbl[2] = '{7'b0110011, 3'b000, 1'b1, 1'b0, 4, 1, 0, 1, 0};  // sub
    tbl[3] = '{7'b0000011, 3'b010, 1'b0, 1'b0, 5, 1, 0, 1, 0};  // lw
    tbl[4] = '{7'b0100011, 3'b010, 1'b0, 1'b0, 4, 0, 1, 1, 0};  // sw
    tbl[5] = '{7'b1100011, 3'b000, 1'b0, 1'b1, 3, 0, 0, 2, 0};  // beq taken
    tbl[6] = '{7'b1100011, 3'b000, 1'b0, 1'b0, 3, 0, 0, 1, 0};  // beq not taken
    tbl[7] = '{7'b1100011, 3'b001, 1'b0, 1'b1, 3, 0, 0, 1, 0};  // bne: no branch
    tbl[8] = '{7'b1101111, 3'b000, 1'b0, 1'b0, 4, 1, 0, 2, 0};  // jal
    tbl[9] = '{7'b0000000, 3'b000, 1'b0, 1'b0, 2, 0, 0, 1, 1};  // illegal

    rst_n = 1'b0; mem_ready = 1'b0; op = 7'd0; funct3 = 3'd0; funct7_5 = 1'b0; zero = 1'b0;
    #12;
    check("reset_strobes", {59'd0, irwrite, pcwrite, memwrite, regwrite, illegal}, 64'd0);
    check("reset_selects", {54'd0, adrsrc, alusrca, alusrcb, resultsrc, immsrc, alucontrol},
          {54'd0, 1'b0, 2'b00, 2'b10, 2'b10, 2'b00, 3'b000});
    check("reset_instret", {32'd0, instret}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      run_instr(tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].z, 0, 0, c, rw, mw, pw, il);
      check($sformatf("table[%0d] cyc/rw/mw/pw/ill", i),
            {c[15:0], rw[7:0], mw[7:0], pw[7:0], il[7:0], 16'd0},
            {tbl[i].cyc[15:0], tbl[i].rw[7:0], tbl[i].mw[7:0], tbl[i].pw[7:0], tbl[i].ill[7:0], 16'd0});
    end

    // lw with two wait cycles in the data read
    run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 2, 2, c, rw, mw, pw, il);
    check("lw_stall2 cyc/rw", {32'd0, c[15:0], rw[15:0]}, {32'd0, 16'd7, 16'd1});

    // Randomized instruction mix with random memory wait states
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
            7'b1100011, 7'b1101111, 7'b0000000, 7'b1110011};
    for (int i = 0; i < 60; i++) begin
      logic [6:0] ro;
      ro = ops[$urandom_range(0, 7)];
      if ($urandom_range(0, 7) == 0) ro = 7'($urandom);
      run_instr(ro, 3'($urandom), 1'($urandom), 1'($urandom), 1, 0, c, rw, mw, pw, il);
    end

    // Reset asserted during a store that is completing
    op = 7'b0100011; funct3 = 3'b010; mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("sw_memwrite_before_reset", {63'd0, memwrite}, 64'd1);
    rst_n = 1'b0; mem_ready = 1'b1;
    #1;
    check("reset_mid_memwrite", {60'd0, memwrite, regwrite, resultsrc == 2'b10, alusrcb == 2'b10},
          {60'd0, 1'b0, 1'b0, 1'b1, 1'b1});
    check("reset_mid_instret", {32'd0, instret}, 64'd0);
    exp_ret = 0;
    mem_ready = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_instr(7'b0010011, 3'b000, 1'b0, 1'b0, 0, 0, c, rw, mw, pw, il);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
